// File: rtl/forward_select_unit.sv
// EX-stage operand forwarding select and load-use stall generator.
// Tracks destination registers of EX/MEM/WB and registers selects for the instruction entering EX.
module forward_select_unit #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic              ex_valid
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic              ex_valid_q, ex_rw_q, ex_mr_q;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic              mem_valid_q, mem_rw_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_valid_q, wb_rw_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [1:0]        sel_a_q, sel_b_q, sel_a_d, sel_b_d;
  logic              load_ex;

  // EX/MEM producers as seen by the instruction about to enter EX
  logic ex_prod, mem_prod;
  assign ex_prod  = ex_valid_q  & ex_rw_q  & (ex_rd_q  != '0);
  assign mem_prod = mem_valid_q & mem_rw_q & (mem_rd_q != '0);

  assign stall = id_valid & ex_valid_q & ex_mr_q & (ex_rd_q != '0) &
                 ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  assign load_ex = id_valid & ~stall & ~flush;

  function automatic logic [1:0] pick(input logic [REG_AW-1:0] src);
    if (ex_prod && ex_rd_q == src)        return SEL_MEM;
    else if (mem_prod && mem_rd_q == src) return SEL_WB;
    else                                  return SEL_RF;
  endfunction

  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (load_ex) begin
      sel_a_d = pick(id_rs1);
      sel_b_d = pick(id_rs2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_rd_q     <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
    end else begin
      wb_valid_q  <= mem_valid_q;
      wb_rw_q     <= mem_rw_q;
      wb_rd_q     <= mem_rd_q;
      mem_valid_q <= ex_valid_q;
      mem_rw_q    <= ex_rw_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= load_ex;
      ex_rw_q     <= load_ex & id_reg_write;
      ex_mr_q     <= load_ex & id_mem_read;
      ex_rs1_q    <= load_ex ? id_rs1 : '0;
      ex_rs2_q    <= load_ex ? id_rs2 : '0;
      ex_rd_q     <= load_ex ? id_rd  : '0;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
    end
  end

  // WB and EX source fields are kept for visibility in waves; nothing downstream reads them here
  logic unused_stage_state;
  assign unused_stage_state = ^{wb_valid_q, wb_rw_q, wb_rd_q, ex_rs1_q, ex_rs2_q};

  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;
  assign ex_valid  = ex_valid_q;

endmodule
